prn_chip_scheduler: RTL and testbench

- Time-multiplexes a single shared PRN code generator datapath across NUM_CH tracking channels.
- At start, loads each enabled channel's initial register state into the generator.
- Round-robin arbitrates per-channel chip requests, steps the generator once per grant and counts chips per channel.
- At each code-period boundary (CODE_LEN chips), forces a reload of that channel's generator state.

---
 rtl/prn_chip_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_prn_chip_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/prn_chip_scheduler.sv
// Shares one PRN generator datapath across NUM_CH tracking channels: initial load,
// round-robin chip stepping, per-channel chip counting and period-boundary reloads.
module prn_chip_scheduler #(
    parameter int NUM_CH   = 5,
    parameter int CODE_LEN = 10230,
    parameter int CW       = 14,
    parameter int CHW      = 3,
    parameter int WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_req,
    output logic [NUM_CH-1:0] ch_gnt,
    output logic              gen_load,
    output logic              gen_step,
    output logic [CHW-1:0]    gen_sel,
    input  logic              gen_chip,
    input  logic              gen_valid,
    output logic              chip_out,
    output logic [CHW-1:0]    chip_ch,
    output logic [CW-1:0]     chip_idx,
    output logic              chip_valid,
    output logic [NUM_CH-1:0] epoch,
    output logic              busy,
    output logic              err
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | one cycle per channel index, loads enabled channels
    // ARB    | round-robin search for a requesting channel
    // STEP   | generator advances granted channel by one chip
    // WAIT   | waiting for gen_valid, bounded by WAIT_MAX cycles
    // RELOAD | period boundary, reload granted channel's state
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARB, S_STEP, S_WAIT, S_RELOAD
    } state_t;

    localparam int             TW      = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]  LAST    = CW'(CODE_LEN - 1);
    localparam logic [CHW-1:0] CH_LAST = CHW'(NUM_CH - 1);

    state_t          state_q, state_d;
    logic [CHW-1:0]  idx_q, idx_d;
    logic [CHW-1:0]  rr_q, rr_d;
    logic [CHW-1:0]  sel_q, sel_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q [NUM_CH];
    logic [CW-1:0]   cnt_d [NUM_CH];
    logic            chip_valid_q, chip_valid_d;
    logic            chip_out_q, chip_out_d;
    logic [CHW-1:0]  chip_ch_q, chip_ch_d;
    logic [CW-1:0]   chip_idx_q, chip_idx_d;

    logic [NUM_CH-1:0] req_v;
    logic              arb_found;
    logic [CHW-1:0]    arb_pick;
    logic [CHW-1:0]    cand;

    // Walk the candidates starting just after the last granted channel.
    always_comb begin
        req_v     = ch_en & ch_req;
        arb_found = 1'b0;
        arb_pick  = '0;
        cand      = (rr_q == CH_LAST) ? '0 : rr_q + CHW'(1);
        for (int k = 0; k < NUM_CH; k++) begin
            if (!arb_found && req_v[cand]) begin
                arb_found = 1'b1;
                arb_pick  = cand;
            end
            cand = (cand == CH_LAST) ? '0 : cand + CHW'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rr_d         = rr_q;
        sel_d        = sel_q;
        tmr_d        = tmr_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        chip_valid_d = 1'b0;
        chip_out_d   = chip_out_q;
        chip_ch_d    = chip_ch_q;
        chip_idx_d   = chip_idx_q;
        gen_load     = 1'b0;
        gen_step     = 1'b0;
        gen_sel      = '0;
        ch_gnt       = '0;
        epoch        = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
                end
            end
            S_LOAD: begin
                gen_sel  = idx_q;
                gen_load = ch_en[idx_q];
                if (idx_q == CH_LAST) state_d = S_ARB;
                else                  idx_d   = idx_q + CHW'(1);
            end
            S_ARB: begin
                gen_sel = sel_q;
                if (arb_found) begin
                    rr_d    = arb_pick;
                    sel_d   = arb_pick;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                gen_sel        = sel_q;
                gen_step       = 1'b1;
                ch_gnt[sel_q]  = 1'b1;
                tmr_d          = TW'(WAIT_MAX - 1);
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                gen_sel = sel_q;
                if (gen_valid) begin
                    chip_valid_d = 1'b1;
                    chip_out_d   = gen_chip;
                    chip_ch_d    = sel_q;
                    chip_idx_d   = cnt_q[sel_q];
                    if (cnt_q[sel_q] == LAST) begin
                        epoch[sel_q] = 1'b1;
                        cnt_d[sel_q] = '0;
                        state_d      = S_RELOAD;
                    end else begin
                        cnt_d[sel_q] = cnt_q[sel_q] + CW'(1);
                        state_d      = S_ARB;
                    end
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_RELOAD: begin
                gen_sel  = sel_q;
                gen_load = 1'b1;
                state_d  = S_ARB;
            end
            default: state_d = S_IDLE;
        endcase

        // abort overrides everything, including a start or chip delivery this cycle
        if (abort) begin
            state_d      = S_IDLE;
            idx_d        = idx_q;
            rr_d         = rr_q;
            sel_d        = sel_q;
            tmr_d        = tmr_q;
            err_d        = err_q;
            cnt_d        = cnt_q;
            chip_valid_d = 1'b0;
            chip_out_d   = chip_out_q;
            chip_ch_d    = chip_ch_q;
            chip_idx_d   = chip_idx_q;
            epoch        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            rr_q         <= CH_LAST;
            sel_q        <= '0;
            tmr_q        <= '0;
            err_q        <= 1'b0;
            chip_valid_q <= 1'b0;
            chip_out_q   <= 1'b0;
            chip_ch_q    <= '0;
            chip_idx_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rr_q         <= rr_d;
            sel_q        <= sel_d;
            tmr_q        <= tmr_d;
            err_q        <= err_d;
            chip_valid_q <= chip_valid_d;
            chip_out_q   <= chip_out_d;
            chip_ch_q    <= chip_ch_d;
            chip_idx_q   <= chip_idx_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign chip_valid = chip_valid_q;
    assign chip_out   = chip_out_q;
    assign chip_ch    = chip_ch_q;
    assign chip_idx   = chip_idx_q;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_prn_chip_scheduler.sv
// Directed bench for prn_chip_scheduler; a small generator model answers each
// gen_step with gen_valid in the following cycle when enabled.
module tb_prn_chip_scheduler;

    localparam int NUM_CH   = 5;
    localparam int CODE_LEN = 10230;
    localparam int CW       = 14;
    localparam int CHW      = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic [NUM_CH-1:0] ch_req = '0;
    logic [NUM_CH-1:0] ch_gnt;
    logic              gen_load;
    logic              gen_step;
    logic [CHW-1:0]    gen_sel;
    logic              gen_chip = 1'b0;
    logic              gen_valid = 1'b0;
    logic              chip_out;
    logic [CHW-1:0]    chip_ch;
    logic [CW-1:0]     chip_idx;
    logic              chip_valid;
    logic [NUM_CH-1:0] epoch;
    logic              busy;
    logic              err;

    logic gen_en = 1'b0;
    logic step_seen = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [NUM_CH-1:0] load_mask;

    prn_chip_scheduler #(
        .NUM_CH(NUM_CH), .CODE_LEN(CODE_LEN), .CW(CW), .CHW(CHW), .WAIT_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ch_en(ch_en), .ch_req(ch_req), .ch_gnt(ch_gnt),
        .gen_load(gen_load), .gen_step(gen_step), .gen_sel(gen_sel),
        .gen_chip(gen_chip), .gen_valid(gen_valid),
        .chip_out(chip_out), .chip_ch(chip_ch), .chip_idx(chip_idx),
        .chip_valid(chip_valid), .epoch(epoch), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // generator model: chip value is the inverse of the selected channel's LSB
    always @(negedge clk) begin
        gen_valid = gen_en && step_seen;
        gen_chip  = ~gen_sel[0];
        step_seen = gen_step;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        chk("load_step_excl", {31'd0, gen_load & gen_step}, 32'd0);
    endtask

    task automatic do_start(input logic [NUM_CH-1:0] en);
        ch_en = en;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_cleared", err, 0);
        chk("busy_load", busy, 1);
        repeat (5) tick();
    endtask

    task automatic chip_cycle(input int c, input int idx, input string tag);
        chk({tag, "_gnt"}, ch_gnt, 32'(1 << c));
        chk({tag, "_step"}, gen_step, 1);
        chk({tag, "_sel"}, gen_sel, c);
        tick();
        chk({tag, "_wait_cv"}, chip_valid, 0);
        tick();
        chk({tag, "_cv"}, chip_valid, 1);
        chk({tag, "_ch"}, chip_ch, c);
        chk({tag, "_idx"}, chip_idx, idx);
        chk({tag, "_out"}, chip_out, (c % 2 == 0) ? 1 : 0);
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_gnt", ch_gnt, 0);
        chk("rst_load", gen_load, 0);
        chk("rst_step", gen_step, 0);
        chk("rst_sel", gen_sel, 0);
        chk("rst_cv", chip_valid, 0);
        chk("rst_idx", chip_idx, 0);
        chk("rst_epoch", epoch, 0);
        rst_n = 1'b1;
        tick();

        // load sequence with 5'b10101
        load_mask = 5'b10101;
        ch_en = load_mask;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            chk("load_en", gen_load, load_mask[i]);
            chk("load_sel", gen_sel, i);
            chk("load_busy", busy, 1);
            tick();
        end
        chk("arb_busy", busy, 1);
        chk("arb_load", gen_load, 0);
        chk("arb_step", gen_step, 0);

        // round robin across all channels
        ch_en = 5'b11111;
        ch_req = 5'b11111;
        gen_en = 1'b1;
        tick();
        for (int g = 0; g < 6; g++) begin
            chip_cycle(g % NUM_CH, g / NUM_CH, "rr");
            if (g == 5) ch_req = '0;
            tick();
        end
        chk("rr_idle_arb_step", gen_step, 0);
        chk("rr_idle_arb_gnt", ch_gnt, 0);

        // generator timeout
        gen_en = 1'b0;
        ch_req = 5'b00001;
        tick();
        chk("to_gnt", ch_gnt, 5'b00001);
        for (int w = 0; w < 4; w++) begin
            tick();
            chk("to_wait_busy", busy, 1);
            chk("to_wait_err", err, 0);
            chk("to_wait_cv", chip_valid, 0);
        end
        tick();
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_cv", chip_valid, 0);
        ch_req = '0;
        gen_en = 1'b1;
        do_start(5'b11111);

        // abort together with start during WAIT
        ch_req = 5'b00001;
        tick();
        chk("ab_gnt", ch_gnt, 5'b00001);
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        ch_req = '0;
        chk("ab_busy", busy, 0);
        chk("ab_cv", chip_valid, 0);
        chk("ab_step", gen_step, 0);
        chk("ab_load", gen_load, 0);
        chk("ab_err", err, 0);
        tick();
        chk("ab_start_ignored", busy, 0);

        // ch_en[1] dropped during its STEP
        do_start(5'b11111);
        ch_req = 5'b00010;
        tick();
        chk("drop_gnt", ch_gnt, 5'b00010);
        ch_en = 5'b11101;
        tick();
        tick();
        chk("drop_cv", chip_valid, 1);
        chk("drop_ch", chip_ch, 1);
        chk("drop_idx", chip_idx, 0);
        ch_req = 5'b00011;
        tick();
        chip_cycle(0, 0, "drop_ch0");
        ch_req = 5'b00010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drop_no_gnt", ch_gnt, 0);
            chk("drop_no_load", gen_load, 0);
        end
        ch_en = 5'b11111;
        tick();
        chk("reen_no_load", gen_load, 0);
        chip_cycle(1, 1, "reen");
        ch_req = '0;

        // full code period on channel 2
        do_start(5'b00100);
        ch_req = 5'b00100;
        for (int k = 0; k < CODE_LEN; k++) begin
            tick();
            tick();
            chk("per_epoch", epoch, (k == CODE_LEN - 1) ? 5'b00100 : 5'b00000);
            tick();
            chk("per_cv", chip_valid, 1);
            chk("per_idx", chip_idx, k);
        end
        chk("per_reload", gen_load, 1);
        chk("per_reload_sel", gen_sel, 2);
        chk("per_reload_ch", chip_ch, 2);
        tick();
        chk("per_arb_load", gen_load, 0);
        tick();
        chip_cycle(2, 0, "per_wrap");
        ch_req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
